// File: rtl/vector_lsu.sv
// Vector load/store unit: unit-stride, strided gather/scatter and scalar element
// access against a wide single-port RAM with a fixed read latency.
module vector_lsu #(
    parameter int LANES  = 8,
    parameter int ELEM_W = 32,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2,
    localparam int LOG2L = $clog2(LANES),
    localparam int VW    = LANES * ELEM_W,
    localparam int EA_W  = ADDR_W + LOG2L,
    localparam int EB    = ELEM_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_mode,
    input  logic [EA_W-1:0]   req_base,
    input  logic [15:0]       req_stride,
    input  logic [VW-1:0]     req_wdata,
    output logic              resp_valid,
    output logic [VW-1:0]     resp_data,
    output logic [ADDR_W-1:0] address_RAM,
    output logic [VW/8-1:0]   byteena_RAM,
    input  logic [VW-1:0]     readData_RAM,
    output logic [VW-1:0]     writeData_RAM,
    output logic              rden_RAM,
    output logic              wren_RAM
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    // Tag that travels alongside each outstanding read beat.
    typedef struct packed {
        logic             valid;
        logic [LOG2L-1:0] lane;
        logic [LOG2L-1:0] idx;
    } rd_tag_t;

    state_t           state;
    logic             op_write;
    logic             op_unit;
    logic             op_strided;
    logic [15:0]      op_stride;
    logic [VW-1:0]    op_wdata;
    logic [EA_W-1:0]  cur_ea;
    logic [LOG2L-1:0] cur_idx;
    logic [VW-1:0]    result_buf;
    rd_tag_t          rd_pipe [RD_LAT];

    logic             issue_beat;
    logic             sel_unit;
    logic             sel_write;
    logic [EA_W-1:0]  sel_ea;
    logic [LOG2L-1:0] sel_idx;
    logic [VW-1:0]    sel_wdata;
    logic [ELEM_W-1:0] sel_elem;
    logic [VW/8-1:0]  beat_be;
    logic [VW-1:0]    beat_wdata;
    rd_tag_t          tail;
    logic [VW-1:0]    merged;
    logic             younger_busy;

    assign issue_beat = ((state == IDLE) && req_valid) ||
                        ((state == ISSUE) && op_strided && !(&cur_idx));

    // Beat 0 comes straight from the request; later beats step the captured address.
    always_comb begin
        sel_unit  = op_unit;
        sel_write = op_write;
        sel_ea    = cur_ea + EA_W'($signed(op_stride));
        sel_idx   = cur_idx + LOG2L'(1);
        sel_wdata = op_wdata;
        if (state == IDLE) begin
            sel_unit  = (req_mode == 2'b00);
            sel_write = req_write;
            sel_ea    = req_base;
            sel_idx   = '0;
            sel_wdata = req_wdata;
        end
        sel_elem   = sel_wdata[sel_idx*ELEM_W +: ELEM_W];
        beat_be    = '0;
        beat_be[sel_ea[LOG2L-1:0]*EB +: EB] = '1;
        beat_wdata = {LANES{sel_elem}};
        if (sel_unit) begin
            beat_be    = '1;
            beat_wdata = sel_wdata;
        end
    end

    assign tail = rd_pipe[RD_LAT-1];

    always_comb begin
        merged = result_buf;
        if (tail.valid) begin
            if (op_unit)
                merged = readData_RAM;
            else
                merged[tail.idx*ELEM_W +: ELEM_W] = readData_RAM[tail.lane*ELEM_W +: ELEM_W];
        end
        younger_busy = rden_RAM;
        for (int i = 0; i < RD_LAT - 1; i++)
            younger_busy = younger_busy | rd_pipe[i].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            address_RAM   <= '0;
            byteena_RAM   <= '0;
            writeData_RAM <= '0;
            rden_RAM      <= 1'b0;
            wren_RAM      <= 1'b0;
            op_write      <= 1'b0;
            op_unit       <= 1'b0;
            op_strided    <= 1'b0;
            op_stride     <= '0;
            op_wdata      <= '0;
            cur_ea        <= '0;
            cur_idx       <= '0;
            result_buf    <= '0;
            // NOTE: the tag pipe is reset so reads in flight at reset are dropped.
            for (int i = 0; i < RD_LAT; i++)
                rd_pipe[i] <= '0;
        end else begin
            resp_valid <= 1'b0;
            rd_pipe[0] <= '{rden_RAM, cur_ea[LOG2L-1:0], cur_idx};
            for (int i = 1; i < RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            if (tail.valid)
                result_buf <= merged;

            if (issue_beat) begin
                address_RAM   <= sel_ea[EA_W-1:LOG2L];
                byteena_RAM   <= beat_be;
                writeData_RAM <= sel_write ? beat_wdata : '0;
                rden_RAM      <= !sel_write;
                wren_RAM      <= sel_write;
                cur_ea        <= sel_ea;
                cur_idx       <= sel_idx;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_write   <= req_write;
                        op_unit    <= (req_mode == 2'b00);
                        op_strided <= (req_mode == 2'b01);
                        op_stride  <= req_stride;
                        op_wdata   <= req_wdata;
                        result_buf <= '0;
                        req_ready  <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!issue_beat) begin
                        rden_RAM      <= 1'b0;
                        wren_RAM      <= 1'b0;
                        byteena_RAM   <= '0;
                        writeData_RAM <= '0;
                        if (op_write) begin
                            resp_valid <= 1'b1;
                            req_ready  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The final return is the only entry left once nothing younger is in flight.
                    if (tail.valid && !younger_busy) begin
                        resp_data  <= merged;
                        resp_valid <= 1'b1;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Parametrised vector load/store unit between the SIMD pipeline's memory stage and the wide single-port data RAM (14-bit line address, 256-bit line, byte enables, separate rden/wren). Unlike a direct line-wide pass-through, it supports three access modes: unit-stride line access, strided gather/scatter of individual elements, and scalar element access. It sequences multi-beat RAM traffic, tracks the RAM read latency and assembles the result vector. The pipeline sees a valid/ready request and a single-cycle completion pulse.

## Interface
- LANES, 8: elements per vector; power of two ≥ 2. LOG2L = log2(LANES).
- ELEM_W, 32: element width in bits; multiple of 8.
- ADDR_W, 14: RAM line-address width.
- RD_LAT, 2: RAM read latency in cycles from the rden edge to valid readData_RAM; ≥ 1.
- Derived: VW = LANES*ELEM_W; EA_W = ADDR_W+LOG2L (element address width).
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_mode  in  2  00 = unit-stride, 01 = strided, 10 = scalar; 11 = reserved, treated as 10.
- req_base  in  EA_W  element address; line = [EA_W-1:LOG2L], lane = [LOG2L-1:0].
- req_stride  in  16  signed element stride; used only in strided mode.
- req_wdata  in  VW  store data; element i = bits [i*ELEM_W +: ELEM_W].
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- resp_data  out  VW  load result; held until the next completion.
- address_RAM  out  ADDR_W  RAM line address.
- byteena_RAM  out  VW/8  byte enables.
- readData_RAM  in  VW  RAM read data.
- writeData_RAM  out  VW  RAM write data.
- rden_RAM, wren_RAM  out  1 each  RAM read and write strobes.

## Operation
- All outputs are registered. req_ready = (state == IDLE).
- Reset values: state IDLE (req_ready = 1); resp_valid, rden_RAM and wren_RAM = 0; address_RAM, byteena_RAM, writeData_RAM and resp_data = 0.
- Asynchronous reset mid-operation aborts immediately. Outstanding read returns are discarded and no resp_valid is produced.
- Accept happens on an edge where req_valid & req_ready. All request fields are captured at that edge. req_valid while busy is ignored and not queued.
- FSM states: IDLE → ISSUE → DRAIN (loads only) → IDLE. resp_valid is asserted on the edge that re-enters IDLE.
- Beat count N: N = 1 for unit-stride and scalar; N = LANES for strided.
- Element address of beat i: ea_i = req_base + i*sext(req_stride), truncated to EA_W bits, so it wraps modulo 2^EA_W. Stride 0 is legal.
- Unit-stride: the lane bits of req_base are ignored and the line is forced aligned. Load: rden_RAM for one beat, and resp_data = readData_RAM. Store: wren_RAM with all byte enables set and writeData_RAM = req_wdata.
- Strided and scalar beats:
  - address_RAM = ea_i line.
  - Store: byteena_RAM has only the ELEM_W/8 bytes of lane ea_i[LOG2L-1:0] set. writeData_RAM carries element i in every lane.
  - Load: lane ea_i is extracted from the returned line into result element i. Scalar load places it in element 0; all other elements are 0.
- Loads: a RD_LAT-deep shift register carries (valid, lane, dest index) per beat. Capture occurs when the entry emerges. DRAIN waits until the shift register is empty.
- Stride-0 strided store: all beats hit the same lane, and element LANES-1 is the final value. Stride-0 strided load replicates one element into every lane.
- Strobes are exactly one cycle per beat. rden_RAM and wren_RAM are never asserted together. Between operations both are 0 and byteena_RAM = 0.

## Timing
- Cycle numbering: accept edge = cycle 0. Beat i drives the RAM strobes during cycle 1+i.
- Load data for beat i is sampled at the edge ending cycle 1+i+RD_LAT.
- Completion (resp_valid high):
  - Store: cycle N+1.
  - Load: cycle N+RD_LAT+1.
- Throughput: one beat per cycle, with no bubbles between beats.
- Back-to-back operations: req_ready is high in the same cycle resp_valid is high. A request accepted on that edge issues its first beat one cycle later.
- resp_data updates on the same edge that raises resp_valid. It is unchanged by stores.

## Test plan
(LANES=8, ELEM_W=32, ADDR_W=14, RD_LAT=2.)
- Unit-stride load, req_base=0x45, RAM line 8 preloaded with pattern P → one rden cycle at address 8 in cycle 1 → resp_valid only in cycle 4, resp_data=P.
- Strided store, base=3, stride=9, element i=0x100+i → wren in cycles 1–8. Beat i has address (3+9i)>>3 and byteena=0xF<<(4*((3+9i)&7)) → resp_valid in cycle 9. RAM contents are checked afterwards.
- Strided load of the same base and stride → resp_valid in cycle 11, element i=0x100+i. Issue it back-to-back with the store: accept in the store's resp cycle, first rden in cycle 10 of the store.
- Wrap and stride 0:
  - Strided store, base=0, stride=-1 → beat 1 at line 0x3FFF, byteena=0xF<<28.
  - Stride-0 load of element address 13 → all 8 result elements equal line 1 lane 5.
- Scalar load of element address 13 → element 0 = line 1 lane 5, others 0, resp_valid in cycle 4. Scalar store → a single wren with byteena=0xF<<20.
- Reset asserted in cycle 3 of a strided load → all outputs return to reset values immediately and req_ready=1. No resp_valid follows. A subsequent unit-stride load completes normally.
